// File: rtl/spi_pkg.sv
// Shared definitions for the SPI request sequencer: FSM encodings, FIFO entry
// layout and default parameter values.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } seq_state_t;

  localparam int DEF_PREW    = 4;
  localparam int DEF_GAP     = 2;
  localparam int DEF_TIMEOUT = 1023;
  localparam int TMO_W       = 16;
  localparam int ENTRY_W     = 8 + 2 + DEF_PREW;

  // Entry is {cpre, cpha, cpol, data}.
  function automatic int entry_width(input int prew);
    return 8 + 2 + prew;
  endfunction

endpackage

// File: rtl/spi_seq_fifo.sv
// Synchronous request FIFO with registered pointers; the head word is read
// combinationally so it can be popped straight into the sequencer's held registers.
module spi_seq_fifo #(
  parameter int  DEPTH = 4,
  parameter int  WIDTH = 14,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // The extra MSB on each pointer separates full from empty.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr_reg[AW-1:0]];
  assign level = wr_ptr_reg - rd_ptr_reg;
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (level == (AW+1)'(DEPTH));

endmodule

// File: rtl/spi_seq.sv
// Serialises queued host byte requests into single SPI transfers with an idle gap.
// Optional WAIT timeout is enabled by defining SPI_SEQ_TIMEOUT_EN.
module spi_seq
  import spi_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int GAP     = DEF_GAP,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int PREW    = DEF_PREW
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    ReqValid,
  output logic                    ReqReady,
  input  logic [7:0]              ReqData,
  input  logic                    ReqCPol,
  input  logic                    ReqCPha,
  input  logic [PREW-1:0]         ReqCPre,
  output logic                    StartTx,
  output logic                    CPol,
  output logic                    CPha,
  output logic [PREW-1:0]         CPre,
  output logic [7:0]              TxData,
  input  logic                    EndTx,
  input  logic [7:0]              RxData,
  output logic                    RspValid,
  input  logic                    RspReady,
  output logic [7:0]              RspData,
  output logic                    RspErr,
  output logic                    Abort,
  output logic                    Busy,
  output logic [$clog2(DEPTH):0]  Level
);

  localparam int EW = entry_width(PREW);

  seq_state_t      state_reg, state_next;
  logic [EW-1:0]   fifo_wdata, fifo_rdata;
  logic            fifo_full, fifo_empty, fifo_pop;
  logic [7:0]      gap_reg, gap_next;
  logic            cpol_reg, cpha_reg;
  logic [PREW-1:0] cpre_reg;
  logic [7:0]      txd_reg;
  logic            start_reg, start_next;
  logic            rsp_valid_reg, rsp_valid_next;
  logic [7:0]      rsp_data_reg, rsp_data_next;
  logic            rsp_err_reg, rsp_err_next;
  logic            abort_reg, abort_next;
  logic            timeout_hit;

  assign fifo_wdata = {ReqCPre, ReqCPha, ReqCPol, ReqData};
  assign fifo_pop   = (state_reg == ST_IDLE) && (gap_reg == 8'd0) && !fifo_empty;

  spi_seq_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_fifo (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .push  (ReqValid && ReqReady),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (Level)
  );

`ifdef SPI_SEQ_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt_reg;

  // Cleared in LAUNCH, so it equals the number of WAIT cycles already elapsed.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                     tmo_cnt_reg <= '0;
    else if (state_reg == ST_LAUNCH) tmo_cnt_reg <= '0;
    else if (state_reg == ST_WAIT)   tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
  end

  assign timeout_hit = (state_reg == ST_WAIT) && (tmo_cnt_reg == TMO_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (fifo_pop) state_next = ST_LAUNCH;
      ST_LAUNCH: state_next = ST_WAIT;
      ST_WAIT:   if (EndTx || timeout_hit) state_next = ST_RESP;
      ST_RESP:   if (RspReady) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    gap_next       = gap_reg;
    start_next     = 1'b0;
    rsp_valid_next = (state_next == ST_RESP);
    rsp_data_next  = rsp_data_reg;
    rsp_err_next   = rsp_err_reg;
    abort_next     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (gap_reg != 8'd0) gap_next = gap_reg - 8'd1;
        start_next = fifo_pop;
      end
      ST_WAIT: begin
        // A completion in the expiry cycle takes priority over the timeout.
        if (EndTx) begin
          rsp_data_next = RxData;
          rsp_err_next  = 1'b0;
        end else if (timeout_hit) begin
          rsp_data_next = 8'h00;
          rsp_err_next  = 1'b1;
          abort_next    = 1'b1;
        end
      end
      ST_RESP: if (RspReady) gap_next = 8'(GAP);
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      gap_reg       <= 8'd0;
      start_reg     <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= 8'h00;
      rsp_err_reg   <= 1'b0;
      abort_reg     <= 1'b0;
      cpol_reg      <= 1'b0;
      cpha_reg      <= 1'b0;
      cpre_reg      <= '0;
      txd_reg       <= 8'h00;
    end else begin
      gap_reg       <= gap_next;
      start_reg     <= start_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_err_reg   <= rsp_err_next;
      abort_reg     <= abort_next;
      if (fifo_pop) begin
        cpre_reg <= fifo_rdata[EW-1 -: PREW];
        cpha_reg <= fifo_rdata[9];
        cpol_reg <= fifo_rdata[8];
        txd_reg  <= fifo_rdata[7:0];
      end
    end
  end

  assign ReqReady = !fifo_full;
  assign StartTx  = start_reg;
  assign CPol     = cpol_reg;
  assign CPha     = cpha_reg;
  assign CPre     = cpre_reg;
  assign TxData   = txd_reg;
  assign RspValid = rsp_valid_reg;
  assign RspData  = rsp_data_reg;
  assign RspErr   = rsp_err_reg;
  assign Abort    = abort_reg;
  assign Busy     = (state_reg != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_spi_seq.sv
// Self-checking bench for spi_seq: table-driven single transfers plus hand-written
// full-FIFO, gap, backpressure, timeout and reset sequences, with launch/response scoreboards.
`timescale 1ns/1ps
module tb_spi_seq;
  localparam int DEPTH = 4, GAP = 2, TIMEOUT = 20, PREW = 4;

  logic Clk = 1'b0, Rst_n = 1'b0;
  logic ReqValid, ReqReady, ReqCPol, ReqCPha, StartTx, CPol, CPha, EndTx;
  logic RspValid, RspReady, RspErr, Abort, Busy;
  logic [7:0] ReqData, TxData, RxData, RspData;
  logic [PREW-1:0] ReqCPre, CPre;
  logic [$clog2(DEPTH):0] Level;

  typedef struct { logic [7:0] data; logic cpol; logic cpha; logic [3:0] cpre; logic [7:0] rx; int dly; } vec_t;
  typedef struct { logic [7:0] data; logic cpol; logic cpha; logic [3:0] cpre; } launch_t;
  typedef struct { logic [7:0] data; logic err; } rsp_t;

  launch_t launch_q[$];
  rsp_t    rsp_q[$];
  int total = 0, bad = 0, n_rsp = 0, cyc = 0;

  spi_seq #(.DEPTH(DEPTH), .GAP(GAP), .TIMEOUT(TIMEOUT), .PREW(PREW)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqData(ReqData),
    .ReqCPol(ReqCPol), .ReqCPha(ReqCPha), .ReqCPre(ReqCPre), .StartTx(StartTx), .CPol(CPol),
    .CPha(CPha), .CPre(CPre), .TxData(TxData), .EndTx(EndTx), .RxData(RxData),
    .RspValid(RspValid), .RspReady(RspReady), .RspData(RspData), .RspErr(RspErr),
    .Abort(Abort), .Busy(Busy), .Level(Level)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Scoreboard: launches and responses are compared as the DUT produces them.
  always @(negedge Clk) begin
    launch_t le;
    rsp_t    re;
    if (Rst_n) begin
      if (StartTx) begin
        if (launch_q.size() == 0) begin
          total++; bad++;
          $display("FAIL launch_unexpected: got StartTx TxData=%02h want no launch", TxData);
        end else begin
          le = launch_q.pop_front();
          chk("launch_txdata", TxData, le.data);
          chk("launch_mode", {CPre, CPha, CPol}, {le.cpre, le.cpha, le.cpol});
        end
      end
      if (RspValid && RspReady) begin
        n_rsp++;
        $display("rsp %0d: data=%02h err=%0b", n_rsp, RspData, RspErr);
        if (rsp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rsp_unexpected: got data=%02h want no response", RspData);
        end else begin
          re = rsp_q.pop_front();
          chk("rsp_data", RspData, re.data);
          chk("rsp_err", RspErr, re.err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic push_req(input logic [7:0] d, input logic pol, input logic pha,
                          input logic [3:0] pre, output int acc);
    int n = 0;
    ReqData = d; ReqCPol = pol; ReqCPha = pha; ReqCPre = pre; ReqValid = 1'b1;
    while (!ReqReady && n < 200) begin tick(); n++; end
    if (!ReqReady) begin
      total++; bad++;
      $display("FAIL push_timeout: ReqReady=%0b want 1", ReqReady);
    end
    acc = cyc;
    launch_q.push_back('{d, pol, pha, pre});
    tick();
    ReqValid = 1'b0;
  endtask

  task automatic wait_start(output int s);
    int n = 0;
    while (!StartTx && n < 200) begin tick(); n++; end
    if (!StartTx) begin
      total++; bad++;
      $display("FAIL start_timeout: StartTx=%0b want 1", StartTx);
    end
    s = cyc;
  endtask

  task automatic end_tx(input logic [7:0] rx);
    RxData = rx; EndTx = 1'b1;
    rsp_q.push_back('{rx, 1'b0});
    tick();
    EndTx = 1'b0;
  endtask

  initial begin
    vec_t vt[4];
    int acc, s, m, n;
    logic ok;
    logic [7:0] hold_d;
    vt[0] = '{8'hA5, 1'b0, 1'b1, 4'd3, 8'h3C, 40};
    vt[1] = '{8'h5A, 1'b1, 1'b0, 4'd7, 8'hC3, 3};
    vt[2] = '{8'hFF, 1'b1, 1'b1, 4'hF, 8'h00, 1};
    vt[3] = '{8'h00, 1'b0, 1'b0, 4'd0, 8'hFF, 10};

    ReqValid = 0; ReqData = 0; ReqCPol = 0; ReqCPha = 0; ReqCPre = 0;
    EndTx = 0; RxData = 0; RspReady = 0;
    Rst_n = 0;
    repeat (3) tick();
    chk("rst_reqready", ReqReady, 1);
    chk("rst_level", Level, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_outputs", {StartTx, RspValid, RspErr, Abort, CPol, CPha}, 0);
    chk("rst_data", {RspData, TxData, CPre}, 0);
    Rst_n = 1;
    tick();

    EndTx = 1; RxData = 8'h77; tick(); EndTx = 0; tick();
    chk("endtx_idle_rspvalid", RspValid, 0);
    chk("endtx_idle_busy", Busy, 0);

    RspReady = 1;
    for (int i = 0; i < 4; i++) begin
      repeat (4) tick();
      push_req(vt[i].data, vt[i].cpol, vt[i].cpha, vt[i].cpre, acc);
      wait_start(s);
      chk("start_latency", s - acc, 2);
      ok = 1'b1;
      for (int k = 0; k < vt[i].dly; k++) begin
        tick();
        if ({CPre, CPha, CPol, TxData} !== {vt[i].cpre, vt[i].cpha, vt[i].cpol, vt[i].data}) ok = 1'b0;
        if (StartTx || RspValid) ok = 1'b0;
      end
      chk("held_stable", ok, 1);
      end_tx(vt[i].rx);
      chk("rsp_valid_latency", RspValid, 1);
    end

    // Full FIFO while the FSM sits in WAIT.
    repeat (4) tick();
    push_req(8'h10, 1'b0, 1'b0, 4'd1, acc);
    wait_start(s);
    for (int i = 1; i <= 4; i++) push_req(8'(8'h10 + i), i[0], i[1], 4'(i), acc);
    chk("full_level", Level, 4);
    chk("full_reqready", ReqReady, 0);
    chk("full_busy", Busy, 1);
    ReqData = 8'h15; ReqCPol = 1; ReqCPha = 0; ReqCPre = 4'd5; ReqValid = 1;
    ok = 1'b1;
    repeat (5) begin tick(); if (ReqReady || Level != 4) ok = 1'b0; end
    chk("full_holdoff", ok, 1);
    end_tx(8'hE0);
    m = cyc;
    n = 0;
    while (!ReqReady && n < 50) begin tick(); n++; end
    acc = cyc;
    chk("fifth_accept_cycle", acc - m, 4);
    chk("fifth_accept_start", StartTx, 1);
    launch_q.push_back('{8'h15, 1'b1, 1'b0, 4'd5});
    tick();
    ReqValid = 0;
    chk("fifth_level", Level, 4);
    for (int j = 0; j < 4; j++) begin
      repeat (2) tick();
      end_tx(8'(8'hE1 + j));
      m = cyc;
      wait_start(s);
      chk("b2b_gap", s - m, 4);
    end
    repeat (2) tick();
    end_tx(8'hE5);

    // Response backpressure with a second request queued.
    repeat (4) tick();
    RspReady = 0;
    push_req(8'h66, 1'b1, 1'b1, 4'd9, acc);
    push_req(8'h67, 1'b0, 1'b1, 4'd2, acc);
    wait_start(s);
    repeat (3) tick();
    end_tx(8'h5D);
    hold_d = RspData;
    ok = 1'b1;
    repeat (10) begin
      tick();
      if (!RspValid || RspData !== hold_d || StartTx || RspErr) ok = 1'b0;
    end
    chk("bp_stable", ok, 1);
    chk("bp_data", hold_d, 8'h5D);
    RspReady = 1;
    m = cyc;
    tick();
    wait_start(s);
    chk("bp_release_gap", s - m, 4);
    repeat (2) tick();
    end_tx(8'h5E);

    repeat (4) tick();
    push_req(8'h99, 1'b0, 1'b0, 4'd0, acc);
    wait_start(s);
`ifdef SPI_SEQ_TIMEOUT_EN
    repeat (TIMEOUT) tick();
    chk("tmo_abort_early", Abort, 0);
    rsp_q.push_back('{8'h00, 1'b1});
    tick();
    chk("tmo_abort", Abort, 1);
    chk("tmo_rspvalid", RspValid, 1);
    chk("tmo_err", RspErr, 1);
    chk("tmo_data", RspData, 8'h00);
    tick();
    chk("tmo_abort_pulse", Abort, 0);
    repeat (4) tick();
    push_req(8'h9A, 1'b1, 1'b0, 4'd6, acc);
    wait_start(s);
    repeat (TIMEOUT - 1) tick();
    end_tx(8'hC7);
    chk("tmo_tie_abort", Abort, 0);
    chk("tmo_tie_err", RspErr, 0);
    chk("tmo_tie_data", RspData, 8'hC7);
`else
    repeat (40) tick();
    chk("no_tmo_rspvalid", RspValid, 0);
    chk("no_tmo_abort", Abort, 0);
    end_tx(8'h42);
    chk("no_tmo_err", RspErr, 0);
`endif

    // Reset in the middle of WAIT with two entries queued.
    repeat (4) tick();
    push_req(8'hB0, 1'b1, 1'b1, 4'd4, acc);
    wait_start(s);
    push_req(8'hB1, 1'b0, 1'b1, 4'd1, acc);
    push_req(8'hB2, 1'b1, 1'b0, 4'd2, acc);
    chk("pre_rst_level", Level, 2);
    repeat (3) tick();
    Rst_n = 0;
    #1;
    chk("mid_rst_level", Level, 0);
    chk("mid_rst_busy", Busy, 0);
    chk("mid_rst_start", StartTx, 0);
    chk("mid_rst_reqready", ReqReady, 1);
    chk("mid_rst_rspvalid", RspValid, 0);
    chk("mid_rst_txdata", TxData, 0);
    launch_q.delete();
    rsp_q.delete();
    tick();
    Rst_n = 1;
    tick();
    push_req(8'hC1, 1'b0, 1'b1, 4'd8, acc);
    wait_start(s);
    chk("post_rst_latency", s - acc, 2);
    repeat (5) tick();
    end_tx(8'h1E);
    repeat (3) tick();
    chk("launch_q_empty", launch_q.size(), 0);
    chk("rsp_q_empty", rsp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time exceeded, want finish before 2ms");
    $fatal(1, "watchdog expired");
  end

endmodule
